// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM.
//
// Each access is split into two phases, low half and then high half. Each phase lasts
// WAIT_CYCLES clocks. `ready` is low while an access is in flight, so the pipeline stalls.
// All SRAM-side outputs and read_data are registered. Only `ready` is combinational.
//
// Optional feature: define SRAM_PERF_CNT_EN to add the access_count port. It is a saturating
// count of the cycles spent in DONE. When the macro is undefined, the port and the counter
// are absent.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   wr_en, rd_en  store / load request (level, held until ready); a write wins if both are set
//   address       byte address; word index = (address - BASE_ADDR) >> 2, bits [1:0] ignored
//   write_data    store data
//   read_data     load result; updated half by half, held between reads, cleared by reset
//   ready         0 = stall pipeline; 1 = idle with no request, or access done
//   sram_addr     SRAM half-word address {word, half}
//   sram_dq_out   SRAM write data
//   sram_dq_in    SRAM read data
//   sram_dq_oe    1 = drive sram_dq_out onto the bus (write phases only)
//   sram_we_n     SRAM write strobe, active low
//   access_count  (SRAM_PERF_CNT_EN only) saturating count of DONE cycles
//
// WAIT_CYCLES must be in the range 2..15. The phase counter is 4 bits wide.

module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0]       access_count
`endif
);

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-2:0] word_q;
  logic [31:0]       wdata_q;

  logic [31:0]       offset;
  logic [ADDR_W-2:0] word_idx;
  logic              req;
  logic              cnt_last;
  logic [3:0]        cnt_inc;
  logic              unused_addr_bits;

  assign req      = wr_en | rd_en;
  assign offset   = address - BASE_ADDR;
  // Dropping bits [1:0] and keeping ADDR_W-1 bits gives a word index that wraps modulo the SRAM size.
  assign word_idx = offset[ADDR_W:2];
  assign unused_addr_bits = ^{offset[31:ADDR_W+1], offset[1:0]};
  assign cnt_last = (cnt_q == LastCnt);
  assign cnt_inc  = cnt_q + 4'd1;

  assign ready = ((state_q == StIdle) && !req) || (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            // Latch the whole request and set up the low-half phase outputs for cnt == 0.
            state_q     <= StLow;
            cnt_q       <= '0;
            op_wr_q     <= wr_en;
            word_q      <= word_idx;
            wdata_q     <= write_data;
            sram_addr   <= {word_idx, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end

        StLow: begin
          if (cnt_last) begin
            state_q     <= StHigh;
            cnt_q       <= '0;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            sram_we_n   <= ~op_wr_q;
            if (!op_wr_q) begin
              read_data[15:0] <= sram_dq_in;
            end
          end else begin
            cnt_q     <= cnt_inc;
            // The strobe rises on the final cycle of the phase, so data and address stay
            // stable for one hold cycle.
            sram_we_n <= ~(op_wr_q && (cnt_inc != LastCnt));
          end
        end

        StHigh: begin
          if (cnt_last) begin
            state_q    <= StDone;
            cnt_q      <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!op_wr_q) begin
              read_data[31:16] <= sram_dq_in;
            end
          end else begin
            cnt_q     <= cnt_inc;
            sram_we_n <= ~(op_wr_q && (cnt_inc != LastCnt));
          end
        end

        StDone: begin
          // A request that is still asserted here belongs to the access just finished.
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SRAM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      access_count <= '0;
    end else if ((state_q == StDone) && (access_count != 32'hFFFF_FFFF)) begin
      access_count <= access_count + 32'd1;
    end
  end
`endif

  // The write strobe may only be active while the data bus is driven.
  assert property (@(posedge clk) disable iff (rst) !sram_we_n |-> sram_dq_oe);
  // The bus is never driven when no access is in flight.
  assert property (@(posedge clk) disable iff (rst) (state_q == StIdle) |-> !sram_dq_oe);

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_PERF_CNT_EN
  logic [31:0] access_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .ADDR_W(18)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
`ifdef SRAM_PERF_CNT_EN
    ,
    .access_count(access_count)
`endif
  );

  // Asynchronous SRAM model with a deterministic background pattern.
  logic [15:0] mem [0:262143];
  int          we_cnt = 0;

  function automatic logic [15:0] pattern(int a);
    return 16'((a * 40503 + 4660) & 32'hFFFF);
  endfunction

  assign sram_dq_in = mem[sram_addr];

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = pattern(i);
    forever begin
      @(posedge clk);
      if (!sram_we_n) begin
        mem[sram_addr] = sram_dq_out;
        we_cnt++;
      end
    end
  end

  // Reference model: SRAM contents as half-words, plus the last completed load.
  logic [15:0] ref_mem [int];
  logic [31:0] ref_rd = 32'h0;

  function automatic logic [15:0] ref_get(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  function automatic int ref_half(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 4) % 131072) * 2;
  endfunction

  task automatic ref_apply(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int h;
    h = ref_half(a);
    if (wr) begin
      ref_mem[h]     = d[15:0];
      ref_mem[h + 1] = d[31:16];
    end else begin
      ref_rd = {ref_get(h + 1), ref_get(h)};
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one access and observe it until ready returns (bounded wait).
  task automatic txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int wes, output logic [17:0] a_lo,
                     output logic [17:0] a_hi, output logic [31:0] rdata);
    int c;
    int we0;
    a_lo = '1;
    a_hi = '1;
    @(posedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    we0 = we_cnt;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) a_lo = sram_addr;
      if (c == W + 1) a_hi = sram_addr;
      if (ready) break;
    end
    lat = c;
    rdata = read_data;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    wes = we_cnt - we0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [17:0] exp_lo_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat, wes, c, we0;
    logic [17:0] a_lo, a_hi;
    logic [31:0] rdata, a, d;
    logic        wr, rd;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'h1234_5678, 18'h00000, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,         18'h00000, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'hCAFE_BABE, 18'h00002, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,         18'h00002, 32'hCAFE_BABE};
    vecs[4] = '{1'b1, 1'b0, 32'd1031, 32'h0BAD_F00D, 18'h00002, 32'hCAFE_BABE};
    vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'hA5A5_5A5A, 18'h3FFFE, 32'hCAFE_BABE};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h0,         18'h3FFFE, 32'hA5A5_5A5A};
    vecs[7] = '{1'b0, 1'b1, 32'd1030, 32'h0,         18'h00002, 32'h0BAD_F00D};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset we_n", 64'(sram_we_n), 64'd1);
    chk("reset oe", 64'(sram_dq_oe), 64'd0);
    chk("reset read_data", 64'(read_data), 64'd0);
    chk("reset sram_addr", 64'(sram_addr), 64'd0);
    chk("reset dq_out", 64'(sram_dq_out), 64'd0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, lat, wes, a_lo, a_hi, rdata);
      ref_apply(vecs[i].wr, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(2 * W + 1));
      chk($sformatf("vec%0d lo addr", i), 64'(a_lo), 64'(vecs[i].exp_lo_addr));
      chk($sformatf("vec%0d hi addr", i), 64'(a_hi), 64'(vecs[i].exp_lo_addr + 18'd1));
      chk($sformatf("vec%0d read_data", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d we cycles", i), 64'(wes), vecs[i].wr ? 64'(2 * (W - 1)) : 64'd0);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d mem lo", i), 64'(mem[vecs[i].exp_lo_addr]), 64'(vecs[i].data[15:0]));
        chk($sformatf("vec%0d mem hi", i), 64'(mem[vecs[i].exp_lo_addr + 18'd1]),
            64'(vecs[i].data[31:16]));
      end
    end

    // Random accesses against the reference model.
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) rd = 1'b1;
      a = 32'd1024 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      txn(wr, rd, a, d, lat, wes, a_lo, a_hi, rdata);
      ref_apply(wr, a, d);
      chk("rand latency", 64'(lat), 64'(2 * W + 1));
      chk("rand lo addr", 64'(a_lo), 64'(ref_half(a)));
      chk("rand hi addr", 64'(a_hi), 64'(ref_half(a) + 1));
      chk("rand read_data", 64'(rdata), 64'(ref_rd));
      chk("rand we cycles", 64'(wes), wr ? 64'(2 * (W - 1)) : 64'd0);
      if (wr) begin
        chk("rand mem", 64'({mem[ref_half(a) + 1], mem[ref_half(a)]}), 64'(d));
      end
    end

    // A request still held in DONE must not start; the next access begins from IDLE.
    @(posedge clk);
    #1;
    rd_en = 1'b1; address = 32'd1024;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready) break;
    end
    ref_apply(1'b0, 32'd1024, 32'h0);
    chk("held 1st latency", 64'(c), 64'(2 * W + 1));
    chk("held 1st read_data", 64'(read_data), 64'(ref_rd));
    for (c = 1; c < 100; c++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk("held 2nd latency", 64'(c), 64'(2 * W + 2));
    chk("held 2nd read_data", 64'(read_data), 64'(ref_rd));
    @(posedge clk);
    #1;
    rd_en = 1'b0;

    // Give read_data a known nonzero value, then abort a write during HIGH at cnt == 2.
    txn(1'b1, 1'b0, 32'd1428, 32'hDEAD_BEEF, lat, wes, a_lo, a_hi, rdata);
    txn(1'b0, 1'b1, 32'd1428, 32'h0, lat, wes, a_lo, a_hi, rdata);
    chk("pre-abort read_data", 64'(rdata), 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    wr_en = 1'b1; address = 32'd1424; write_data = 32'h1111_2222;
    repeat (8) @(posedge clk);
    #1;
    chk("abort point addr", 64'(sram_addr), 64'd201);
    chk("abort point we_n", 64'(sram_we_n), 64'd0);
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    we0 = we_cnt;
    chk("abort ready", 64'(ready), 64'd1);
    chk("abort we_n", 64'(sram_we_n), 64'd1);
    chk("abort oe", 64'(sram_dq_oe), 64'd0);
    chk("abort read_data", 64'(read_data), 64'd0);
    repeat (2 * W + 4) @(posedge clk);
    #1;
    chk("abort no more writes", 64'(we_cnt - we0), 64'd0);
    chk("abort idle ready", 64'(ready), 64'd1);

`ifdef SRAM_PERF_CNT_EN
    chk("perf after reset", 64'(access_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, 1'b1, 32'd1024 + 32'(4 * i), 32'h0, lat, wes, a_lo, a_hi, rdata);
    end
    chk("perf count 3", 64'(access_count), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("perf reset", 64'(access_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
